// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame definitions: FSM states, parity modes, parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP1 = 3'd4,
    STOP2 = 3'd5
  } state_e;

  localparam string PARITY_ODD  = "ODD";
  localparam string PARITY_EVEN = "EVEN";

  // Parity bit value that completes a frame for the selected mode.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return odd ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte handshake between uart_rx and its upper layer.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       rx_ack;
  logic       par_err;
  logic       frm_err;
  logic       ovr_err;

  modport master (output rx_data, rx_vld, par_err, frm_err, ovr_err, input rx_ack);
  modport slave  (input rx_data, rx_vld, par_err, frm_err, ovr_err, output rx_ack);
endinterface

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser for the serial line, resets to idle-high.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic s1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      q_o  <= 1'b1;
    end else begin
      s1_q <= d_i;
      q_o  <= s1_q;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8-bit UART receiver with parity/stop checks and valid/ack output.
module uart_rx
  import uart_pkg::*;
#(
  parameter string PARITY     = "ODD",
  parameter int    STOP_BIT   = 1,
  parameter int    OVERSAMPLE = 16
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rx_bd_en,
  input  logic     rx,
  uart_rx_if.master rx_if
);
  localparam int            CW      = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_MID = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_END = CW'(OVERSAMPLE - 1);
  localparam bit            PAR_ODD = (PARITY == PARITY_ODD);
  localparam bit            PAR_EN  = PAR_ODD || (PARITY == PARITY_EVEN);

  logic          rx_s;
  state_e        state_q, state_d;
  logic          armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          perr_q, perr_d, ferr_q, ferr_d;
  logic [7:0]    data_q, data_d;
  logic          vld_q, vld_d, pe_q, pe_d, fe_q, fe_d, ovr_q, ovr_d;
  logic          complete, frame_fe;

  uart_sync2 u_sync (.clk(clk), .rst(rst), .d_i(rx), .q_o(rx_s));

  always_comb begin
    state_d  = state_q;
    armed_d  = armed_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    data_d   = data_q;
    vld_d    = vld_q;
    pe_d     = pe_q;
    fe_d     = fe_q;
    ovr_d    = ovr_q;
    complete = 1'b0;
    frame_fe = ferr_q;

    if (rx_bd_en) begin
      case (state_q)
        IDLE: begin
          if (rx_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_q == CNT_MID) begin
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              cnt_d   = '0;
              bit_d   = '0;
              perr_d  = 1'b0;
              ferr_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == CNT_END) begin
            cnt_d   = '0;
            shreg_d = {rx_s, shreg_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = PAR_EN ? PAR : STOP1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PAR: begin
          if (cnt_q == CNT_END) begin
            cnt_d   = '0;
            perr_d  = (rx_s != parity_bit(shreg_q, PAR_ODD));
            state_d = STOP1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STOP1: begin
          if (cnt_q == CNT_END) begin
            cnt_d    = '0;
            frame_fe = ~rx_s;
            ferr_d   = frame_fe;
            if (STOP_BIT == 2) state_d = STOP2;
            else               complete = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STOP2: begin
          if (cnt_q == CNT_END) begin
            cnt_d    = '0;
            frame_fe = ferr_q | ~rx_s;
            ferr_d   = frame_fe;
            complete = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      // Completing at mid-stop leaves half a bit to catch a back-to-back start edge.
      if (complete) begin
        state_d = IDLE;
        if (frame_fe && !rx_s) armed_d = 1'b0;
      end
    end

    if (complete && (!vld_q || rx_if.rx_ack)) begin
      data_d = shreg_q;
      pe_d   = perr_q;
      fe_d   = frame_fe;
      vld_d  = 1'b1;
      if (vld_q) ovr_d = 1'b0;
    end else if (complete) begin
      ovr_d = 1'b1;
    end else if (rx_if.rx_ack && vld_q) begin
      vld_d = 1'b0;
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_if.rx_data = data_q;
  assign rx_if.rx_vld  = vld_q;
  assign rx_if.par_err = pe_q;
  assign rx_if.frm_err = fe_q;
  assign rx_if.ovr_err = ovr_q;
endmodule
